psg_write_arbiter: RTL and testbench
====================================

# psg_write_arbiter

Write scheduler in front of the SN76489-style tone generator's byte bus. It accepts register-update commands from two requesters, for example the CPU port and the music sequencer. It arbitrates between them round-robin and encodes each command into one or two PSG bytes. It then drives each byte onto D/nCE/nWE and holds the strobe until the generator's READY handshake completes. A timeout guards against a stuck READY.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1024: max cycles nWE may stay low per byte before abort.
- RECOVER_CYCLES, 1: cycles nCE/nWE held high between bytes (≥1).

Ports:
- CLK  in  1  system clock; all logic on posedge.
- nRST  in  1  reset, synchronous, active-low.
- req0_valid / req1_valid  in  1  requester N has a command.
- req0_ready / req1_ready  out  1  command N accepted this cycle.
- req0_chan / req1_chan  in  2  target channel 0–3 (3 = noise).
- req0_kind / req1_kind  in  1  0 = tone/noise, 1 = attenuation.
- req0_value / req1_value  in  10  tone period[9:0]; attenuation uses [3:0]; noise uses [2:0].
- D  out  8  PSG data byte.
- nCE  out  1  PSG chip enable, active-low.
- nWE  out  1  PSG write enable, active-low.
- READY  in  1  PSG ready: low while a write is being absorbed.
- busy  out  1  high in every state except IDLE.
- err_timeout  out  1  one-cycle pulse when a byte aborts on timeout.

## Operation
Byte encoding (cmd = captured chan/kind/value):
- Attenuation: one byte, {1, chan, 1, value[3:0]}.
- Tone, chan 0–2: two bytes, latch {1, chan, 0, value[3:0]}, then data {0, 0, value[9:4]}.
- Noise, chan 3, kind 0: one byte, {1, 11, 0, 0, value[2:0]}.

Arbitration:
- Only valid requester in IDLE: granted.
- Both valid: grant the requester not granted last. The rr pointer updates on each grant; reset favours req0.
- reqN_ready = (state==IDLE) & reqN_valid & grantN. It is combinational, and at most one is high per cycle.
- Command fields are captured on the accept edge. Requesters must hold fields stable while valid.

FSM states:
- IDLE → SETUP on accept.
- SETUP (1 cycle): D driven, nCE=0, nWE=1. Next state STROBE.
- STROBE: nCE=0, nWE=0.
  - Sub-flag seen_low sets when READY is sampled 0.
  - Exit when seen_low & READY sampled 1, to RECOVER.
  - If the timeout counter reaches TIMEOUT_CYCLES−1 first: pulse err_timeout, discard any pending second byte, go to RECOVER.
- RECOVER (RECOVER_CYCLES): nCE=1, nWE=1, D holds last byte. Exit to SETUP with the data byte if a second byte is pending, else IDLE.

Rules:
- The timeout counter clears on SETUP entry.
- READY already low on STROBE entry counts as seen_low.
- A new request is never accepted outside IDLE. A pending tone data byte always follows its latch byte with no interleaving.

Reset (nRST low at any edge, including mid-write):
- Outputs: D=0, nCE=1, nWE=1, busy=0, err_timeout=0, both ready=0.
- Internal: state IDLE, rr→req0, pending byte dropped, counter 0.

## Timing
- Accept at edge T (ready high in cycle T−1..T).
- Cycle T+1: SETUP.
- Cycle T+2: first cycle of nWE low.
- Per byte: 1 (SETUP) + strobe length + RECOVER_CYCLES.
- Strobe length ≥ 2 (READY low, then high). With READY pulsing low for exactly 1 cycle right after nWE falls, a one-byte command returns to IDLE at T+5 with RECOVER_CYCLES=1.
- Back-to-back: the next accept can occur in the first IDLE cycle.
- Throughput: one command per (bytes × per-byte time) + 1 cycles.
- err_timeout is asserted in the first RECOVER cycle after abort.

## Structure
- Package psg_pkg holds:
  - State enum {IDLE, SETUP, STROBE, RECOVER}.
  - Channel constants: CH_NOISE=2'd3.
  - Kind constants: KIND_TONE=0, KIND_ATTN=1.
  - Byte-building functions: latch_byte(chan,kind,nib), data_byte(hi6).
- Sub-module psg_rr_arb2: two-input round-robin grant with last-grant register. It is shared later by any other two-master PSG client.
- Counter width is $clog2(TIMEOUT_CYCLES+1).

## Test plan
- Reset mid-STROBE: assert nRST=0 for one edge with nWE low → next cycle nCE=1, nWE=1, D=0, busy=0. A tone in flight is not completed after release.
- req0 attenuation chan1 value 4'hA, READY pulses low for 1 cycle → single byte D=8'hBA, nWE low for 2 cycles, busy drops at T+5.
- req1 tone chan2 value 10'h2F3 → D=8'hC3, then after RECOVER D=8'h2F. Exactly two nWE pulses.
- Both valid continuously, each issuing attenuation → grants alternate req0, req1, req0, req1. The first grant goes to req0 after reset. Never two readys in one cycle.
- Noise chan3 value 3'b101 → one byte D=8'hE5. Tone chan0 value 10'h3FF → D=8'h8F then 8'h3F.
- READY held high (never drops), TIMEOUT_CYCLES=8 → nWE low for exactly 8 cycles, err_timeout pulses once, second tone byte never issued, IDLE reached.

Source files
------------

// File: rtl/psg_pkg.sv
// psg_pkg
// Shared types and helpers for the PSG write path.
//   state_t     : write-scheduler FSM states
//   CH_NOISE    : channel index of the noise generator
//   KIND_TONE / KIND_ATTN : command kind encodings
//   latch_byte  : builds a PSG latch byte {1, chan, kind, nibble}
//   data_byte   : builds a PSG data byte {0, 0, hi6}
package psg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        RECOVER
    } state_t;

    localparam logic [1:0] CH_NOISE  = 2'd3;
    localparam logic       KIND_TONE = 1'b0;
    localparam logic       KIND_ATTN = 1'b1;

    // The kind bit sits in the register-select field of the latch byte, so
    // attenuation and tone/noise latches differ only in bit 4.
    function automatic logic [7:0] latch_byte(input logic [1:0] chan,
                                              input logic       kind,
                                              input logic [3:0] nib);
        return {1'b1, chan, kind, nib};
    endfunction

    function automatic logic [7:0] data_byte(input logic [5:0] hi6);
        return {2'b00, hi6};
    endfunction

endpackage

// File: rtl/psg_write_arbiter_if.sv
// psg_write_arbiter_if
// Bundles the two requester command channels and the PSG byte bus.
//   reqN_valid/ready/chan/kind/value : command handshake from requester N
//   D, nCE, nWE                      : PSG data byte and active-low strobes
//   READY                            : PSG ready, low while absorbing a write
// Modports:
//   slave  : the arbiter (consumes commands, drives the PSG bus)
//   master : the environment (requesters plus the PSG itself)
interface psg_write_arbiter_if;

    logic       req0_valid;
    logic       req0_ready;
    logic [1:0] req0_chan;
    logic       req0_kind;
    logic [9:0] req0_value;

    logic       req1_valid;
    logic       req1_ready;
    logic [1:0] req1_chan;
    logic       req1_kind;
    logic [9:0] req1_value;

    logic [7:0] D;
    logic       nCE;
    logic       nWE;
    logic       READY;

    modport slave (
        input  req0_valid, req0_chan, req0_kind, req0_value,
        input  req1_valid, req1_chan, req1_kind, req1_value,
        output req0_ready, req1_ready,
        output D, nCE, nWE,
        input  READY
    );

    modport master (
        output req0_valid, req0_chan, req0_kind, req0_value,
        output req1_valid, req1_chan, req1_kind, req1_value,
        input  req0_ready, req1_ready,
        input  D, nCE, nWE,
        output READY
    );

endinterface

// File: rtl/psg_rr_arb2.sv
// psg_rr_arb2
// Two-input round-robin arbiter with a last-grant register.
//   CLK, nRST      : clock, synchronous active-low reset
//   req0, req1     : request lines
//   advance        : a grant was taken this cycle; remember who won
//   grant0, grant1 : combinational one-hot (or zero) grant
module psg_rr_arb2 (
    input  logic CLK,
    input  logic nRST,
    input  logic req0,
    input  logic req1,
    input  logic advance,
    output logic grant0,
    output logic grant1
);

    // last1 = 1 means req1 won most recently; resetting it to 1 makes req0
    // the first winner when both ask at once.
    logic last1;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            last1 <= 1'b1;
        end else if (advance) begin
            last1 <= grant1;
        end
    end

    assign grant0 = req0 & (~req1 | last1);
    assign grant1 = req1 & (~req0 | ~last1);

endmodule

// File: rtl/psg_write_arbiter.sv
// psg_write_arbiter
// Accepts register-update commands from two requesters (round-robin),
// encodes each into one or two PSG bytes and strobes them onto the
// SN76489-style bus, waiting for the READY low/high handshake per byte.
//   CLK, nRST   : clock, synchronous active-low reset
//   bus         : command channels + PSG byte bus (slave modport)
//   busy        : high whenever the scheduler is not IDLE
//   err_timeout : one-cycle pulse in the first RECOVER cycle after an abort
module psg_write_arbiter
    import psg_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int RECOVER_CYCLES = 1
) (
    input  logic                 CLK,
    input  logic                 nRST,
    psg_write_arbiter_if.slave   bus,
    output logic                 busy,
    output logic                 err_timeout
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
    localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] R_LAST = RW'(RECOVER_CYCLES - 1);

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] tcnt;
    logic [RW-1:0] rcnt;
    logic          seen_low;
    logic          pend;
    logic [7:0]    pend_byte;
    logic [7:0]    d_q;
    logic          err_q;

    logic          grant0;
    logic          grant1;
    logic          accept;
    logic          strobe_done;
    logic          strobe_abort;
    logic          recover_done;

    logic [1:0]    cmd_chan;
    logic          cmd_kind;
    logic [9:0]    cmd_value;
    logic [7:0]    first_byte;
    logic [7:0]    second_byte;
    logic          needs_second;

    psg_rr_arb2 u_arb (
        .CLK     (CLK),
        .nRST    (nRST),
        .req0    (bus.req0_valid),
        .req1    (bus.req1_valid),
        .advance (accept),
        .grant0  (grant0),
        .grant1  (grant1)
    );

    // Ready is gated by nRST so nothing is accepted while reset is held.
    assign bus.req0_ready = nRST & (state == IDLE) & grant0;
    assign bus.req1_ready = nRST & (state == IDLE) & grant1;
    assign accept         = bus.req0_ready | bus.req1_ready;

    // Select the winning requester's fields and pre-compute its bytes so
    // they can be captured on the accept edge. Only channel 0-2 tones need
    // the second (data) byte; noise packs its 3-bit mode into the latch.
    always_comb begin
        cmd_chan  = bus.req0_chan;
        cmd_kind  = bus.req0_kind;
        cmd_value = bus.req0_value;
        if (grant1) begin
            cmd_chan  = bus.req1_chan;
            cmd_kind  = bus.req1_kind;
            cmd_value = bus.req1_value;
        end

        needs_second = 1'b0;
        second_byte  = data_byte(cmd_value[9:4]);
        if (cmd_kind == KIND_ATTN) begin
            first_byte = latch_byte(cmd_chan, KIND_ATTN, cmd_value[3:0]);
        end else if (cmd_chan == CH_NOISE) begin
            first_byte = latch_byte(CH_NOISE, KIND_TONE, {1'b0, cmd_value[2:0]});
        end else begin
            first_byte   = latch_byte(cmd_chan, KIND_TONE, cmd_value[3:0]);
            needs_second = 1'b1;
        end
    end

    // A completed handshake wins over a timeout landing on the same edge.
    assign strobe_done  = (state == STROBE) & seen_low & bus.READY;
    assign strobe_abort = (state == STROBE) & ~strobe_done & (tcnt == T_LAST);
    assign recover_done = (state == RECOVER) & (rcnt == R_LAST);

    // State register plus the datapath registers that ride along with it.
    // Counters and seen_low clear whenever their state is not active, which
    // also guarantees they start from zero on every SETUP entry.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state     <= IDLE;
            tcnt      <= '0;
            rcnt      <= '0;
            seen_low  <= 1'b0;
            pend      <= 1'b0;
            pend_byte <= 8'h00;
            d_q       <= 8'h00;
            err_q     <= 1'b0;
        end else begin
            state <= state_nx;
            err_q <= strobe_abort;

            if (state == STROBE) begin
                tcnt <= tcnt + 1'b1;
                if (!bus.READY) begin
                    seen_low <= 1'b1;
                end
            end else begin
                tcnt     <= '0;
                seen_low <= 1'b0;
            end

            if (state == RECOVER) begin
                rcnt <= rcnt + 1'b1;
            end else begin
                rcnt <= '0;
            end

            if (accept) begin
                d_q       <= first_byte;
                pend      <= needs_second;
                pend_byte <= second_byte;
            end else if (strobe_abort) begin
                pend <= 1'b0;
            end else if (recover_done && pend) begin
                d_q  <= pend_byte;
                pend <= 1'b0;
            end
        end
    end

    // Next-state logic: a pending data byte loops straight back to SETUP so
    // nothing can slip in between a tone's latch and data bytes.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = SETUP;
            SETUP:   state_nx = STROBE;
            STROBE:  if (strobe_done || strobe_abort) state_nx = RECOVER;
            RECOVER: if (recover_done) state_nx = pend ? SETUP : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output decode: D is registered and simply held; strobes follow state.
    always_comb begin
        busy        = (state != IDLE);
        err_timeout = err_q;
        bus.D       = d_q;
        bus.nCE     = 1'b1;
        bus.nWE     = 1'b1;
        case (state)
            SETUP: begin
                bus.nCE = 1'b0;
            end
            STROBE: begin
                bus.nCE = 1'b0;
                bus.nWE = 1'b0;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_psg_write_arbiter.sv
// tb_psg_write_arbiter
// Drives both requesters from command queues, emulates the PSG READY
// handshake, records every byte strobed onto the bus and compares against a
// queue-level model of arbitration order, byte encoding and timing.
module tb_psg_write_arbiter;

    localparam int TOUT  = 8;
    localparam int RECOV = 1;

    typedef struct packed {
        logic [1:0] chan;
        logic       kind;
        logic [9:0] value;
    } cmd_t;

    logic CLK = 1'b0;
    logic nRST;
    logic busy;
    logic err_timeout;

    psg_write_arbiter_if bus ();

    psg_write_arbiter #(
        .TIMEOUT_CYCLES (TOUT),
        .RECOVER_CYCLES (RECOV)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .bus         (bus.slave),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // PSG emulation: READY goes low low_len cycles starting low_start cycles
    // into the strobe, or never drops while stuck is set.
    bit stuck     = 1'b0;
    int low_start = 0;
    int low_len   = 1;
    int strobe_k  = 0;

    always @(negedge CLK) begin
        if (stuck) begin
            bus.READY = 1'b1;
            strobe_k  = 0;
        end else if (bus.nWE === 1'b0) begin
            bus.READY = !(strobe_k >= low_start && strobe_k < low_start + low_len);
            strobe_k  = strobe_k + 1;
        end else begin
            bus.READY = 1'b1;
            strobe_k  = 0;
        end
    end

    // Bus monitor: one entry per nWE pulse (byte and pulse length), plus the
    // cycle stamps of busy falling and err_timeout pulses.
    logic [7:0] obs_bytes[$];
    int         obs_len[$];
    int         busy_fall[$];
    int         err_cyc[$];
    int         nce_bad   = 0;
    logic       prev_nwe  = 1'b1;
    logic       prev_busy = 1'b0;

    always @(negedge CLK) begin
        if (bus.nWE === 1'b0) begin
            if (prev_nwe === 1'b1) begin
                obs_bytes.push_back(bus.D);
                obs_len.push_back(1);
                if (bus.nCE !== 1'b0) nce_bad = nce_bad + 1;
            end else if (obs_len.size() > 0) begin
                obs_len[obs_len.size() - 1] = obs_len[obs_len.size() - 1] + 1;
            end
        end
        prev_nwe = bus.nWE;
        if (err_timeout === 1'b1) err_cyc.push_back(cyc);
        if (prev_busy === 1'b1 && busy === 1'b0) busy_fall.push_back(cyc);
        prev_busy = busy;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks = checks + 1;
        assert (observed === expected) else begin
            errors = errors + 1;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Command queues feeding the driver, and copies consumed by the model.
    cmd_t q0[$];
    cmd_t q1[$];
    cmd_t m0[$];
    cmd_t m1[$];
    int   acc_cyc[$];
    int   grant_seq[$];
    int   both_ready = 0;

    task automatic addCmd(input int who, input logic [1:0] chan, input logic kind,
                          input logic [9:0] value);
        cmd_t c;
        c.chan  = chan;
        c.kind  = kind;
        c.value = value;
        if (who == 0) begin
            q0.push_back(c);
            m0.push_back(c);
        end else begin
            q1.push_back(c);
            m1.push_back(c);
        end
    endtask

    // Reference model: walk both command lists, grant by alternation when
    // both still have work, and encode each command with plain arithmetic.
    bit         model_last1 = 1'b1;
    int         exp_grant[$];
    logic [7:0] exp_bytes[$];
    int         exp_nb[$];

    task automatic modelRun();
        cmd_t c;
        bit   pick1;
        exp_grant.delete();
        exp_bytes.delete();
        exp_nb.delete();
        while (m0.size() > 0 || m1.size() > 0) begin
            if (m0.size() == 0)      pick1 = 1'b1;
            else if (m1.size() == 0) pick1 = 1'b0;
            else                     pick1 = !model_last1;
            model_last1 = pick1;
            if (pick1) c = m1.pop_front();
            else       c = m0.pop_front();
            exp_grant.push_back(pick1 ? 1 : 0);
            if (c.kind == 1'b1) begin
                exp_bytes.push_back(8'(128 + 32 * int'(c.chan) + 16 + int'(c.value) % 16));
                exp_nb.push_back(1);
            end else if (c.chan == 2'd3) begin
                exp_bytes.push_back(8'(224 + int'(c.value) % 8));
                exp_nb.push_back(1);
            end else begin
                exp_bytes.push_back(8'(128 + 32 * int'(c.chan) + int'(c.value) % 16));
                exp_bytes.push_back(8'(int'(c.value) / 16));
                exp_nb.push_back(2);
            end
        end
    endtask

    // Present queue heads every cycle, note who got ready, pop after the
    // accept edge; stop once both queues are drained and the DUT is idle.
    task automatic applyStimulus(input int budget);
        bit took0;
        bit took1;
        bit done;
        int n;
        took0 = 1'b0;
        took1 = 1'b0;
        done  = 1'b0;
        n     = 0;
        while (!done) begin
            @(negedge CLK);
            if (took0 || took1) acc_cyc.push_back(cyc);
            took0 = 1'b0;
            took1 = 1'b0;
            if (q0.size() == 0 && q1.size() == 0 && busy === 1'b0) begin
                done = 1'b1;
            end else if (n >= budget) begin
                done = 1'b1;
            end else begin
                if (q0.size() > 0) begin
                    bus.req0_valid = 1'b1;
                    bus.req0_chan  = q0[0].chan;
                    bus.req0_kind  = q0[0].kind;
                    bus.req0_value = q0[0].value;
                end else begin
                    bus.req0_valid = 1'b0;
                end
                if (q1.size() > 0) begin
                    bus.req1_valid = 1'b1;
                    bus.req1_chan  = q1[0].chan;
                    bus.req1_kind  = q1[0].kind;
                    bus.req1_value = q1[0].value;
                end else begin
                    bus.req1_valid = 1'b0;
                end
                #1;
                took0 = (bus.req0_ready === 1'b1);
                took1 = (bus.req1_ready === 1'b1);
                if (took0 && took1) both_ready = both_ready + 1;
                if (took0) grant_seq.push_back(0);
                if (took1) grant_seq.push_back(1);
                @(posedge CLK);
                if (took0) void'(q0.pop_front());
                if (took1) void'(q1.pop_front());
                n = n + 1;
            end
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        checkOutput("batch_within_budget", 32'(n < budget), 1);
        repeat (2) @(negedge CLK);
    endtask

    // Run whatever addCmd queued with a given READY profile and compare.
    task automatic runAndCheck(input string name, input int s, input int len);
        int bb;
        int lb;
        int fb;
        int eb;
        int per;
        int nc;
        low_start = s;
        low_len   = len;
        per       = 1 + (s + len + 1) + RECOV;
        bb = obs_bytes.size();
        lb = obs_len.size();
        fb = busy_fall.size();
        eb = err_cyc.size();
        acc_cyc.delete();
        grant_seq.delete();
        both_ready = 0;
        modelRun();
        applyStimulus(400);
        checkOutput({name, "_grant_count"}, grant_seq.size(), exp_grant.size());
        for (int i = 0; i < grant_seq.size() && i < exp_grant.size(); i++)
            checkOutput({name, "_grant"}, grant_seq[i], exp_grant[i]);
        checkOutput({name, "_byte_count"}, obs_bytes.size() - bb, exp_bytes.size());
        for (int i = 0; i < exp_bytes.size() && bb + i < obs_bytes.size(); i++)
            checkOutput({name, "_byte"}, obs_bytes[bb + i], exp_bytes[i]);
        for (int i = lb; i < obs_len.size(); i++)
            checkOutput({name, "_nwe_len"}, obs_len[i], s + len + 1);
        nc = busy_fall.size() - fb;
        checkOutput({name, "_idle_returns"}, nc, exp_nb.size());
        for (int i = 0; i < nc && i < acc_cyc.size() && i < exp_nb.size(); i++)
            checkOutput({name, "_latency"}, busy_fall[fb + i] - acc_cyc[i], exp_nb[i] * per);
        checkOutput({name, "_both_ready"}, both_ready, 0);
        checkOutput({name, "_no_timeout"}, err_cyc.size() - eb, 0);
    endtask

    initial begin
        int bb;
        int eb;
        int fb;
        int n;
        int cnt0;
        int cnt1;

        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_chan  = 2'd0;
        bus.req0_kind  = 1'b0;
        bus.req0_value = 10'd0;
        bus.req1_chan  = 2'd0;
        bus.req1_kind  = 1'b0;
        bus.req1_value = 10'd0;

        // Power-on reset with a request waiting: nothing may be accepted.
        nRST = 1'b0;
        bus.req0_valid = 1'b1;
        repeat (3) @(negedge CLK);
        checkOutput("reset_D", bus.D, 8'h00);
        checkOutput("reset_nCE", bus.nCE, 1'b1);
        checkOutput("reset_nWE", bus.nWE, 1'b1);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_err", err_timeout, 1'b0);
        checkOutput("reset_ready0", bus.req0_ready, 1'b0);
        bus.req0_valid = 1'b0;
        nRST = 1'b1;
        repeat (2) @(negedge CLK);

        // Attenuation ch1 = A, one-cycle READY pulse: 0xBA, back in IDLE at T+5.
        addCmd(0, 2'd1, 1'b1, 10'h00A);
        runAndCheck("attn_ch1", 0, 1);

        // Tone ch2 = 0x2F3 from req1: 0xC3 then 0x2F.
        addCmd(1, 2'd2, 1'b0, 10'h2F3);
        runAndCheck("tone_ch2", 1, 2);

        // Noise (upper bits ignored) and a full-scale tone on ch0.
        addCmd(0, 2'd3, 1'b0, 10'h3FD);
        addCmd(1, 2'd0, 1'b0, 10'h3FF);
        runAndCheck("noise_tone", 0, 2);

        // Stuck READY: the latch byte times out, its data byte is dropped.
        stuck = 1'b1;
        bb = obs_bytes.size();
        eb = err_cyc.size();
        fb = busy_fall.size();
        acc_cyc.delete();
        grant_seq.delete();
        addCmd(0, 2'd1, 1'b0, 10'h155);
        modelRun();
        applyStimulus(100);
        checkOutput("timeout_byte_count", obs_bytes.size() - bb, 1);
        if (obs_bytes.size() > bb)
            checkOutput("timeout_latch_byte", obs_bytes[bb], exp_bytes[0]);
        if (obs_len.size() > 0)
            checkOutput("timeout_nwe_len", obs_len[obs_len.size() - 1], TOUT);
        checkOutput("timeout_err_pulses", err_cyc.size() - eb, 1);
        if (err_cyc.size() > eb && acc_cyc.size() > 0)
            checkOutput("timeout_err_cycle", err_cyc[eb] - acc_cyc[0], 1 + TOUT);
        if (busy_fall.size() > fb && acc_cyc.size() > 0)
            checkOutput("timeout_idle_cycle", busy_fall[fb] - acc_cyc[0], 1 + TOUT + RECOV);
        checkOutput("timeout_busy_after", busy, 1'b0);

        // Reset in the middle of a strobe; the tone must not resume.
        @(negedge CLK);
        bus.req0_valid = 1'b1;
        bus.req0_chan  = 2'd2;
        bus.req0_kind  = 1'b0;
        bus.req0_value = 10'h2F3;
        #1;
        n = 0;
        while (bus.req0_ready !== 1'b1 && n < 20) begin
            @(negedge CLK);
            #1;
            n = n + 1;
        end
        checkOutput("rst_mid_accepted", 32'(n < 20), 1);
        bb = obs_bytes.size();
        eb = err_cyc.size();
        @(posedge CLK);
        #1;
        bus.req0_valid = 1'b0;
        model_last1 = 1'b0;
        n = 0;
        while (bus.nWE !== 1'b0 && n < 20) begin
            @(negedge CLK);
            n = n + 1;
        end
        repeat (2) @(negedge CLK);
        checkOutput("rst_mid_pre_nwe", bus.nWE, 1'b0);
        nRST = 1'b0;
        @(negedge CLK);
        checkOutput("rst_mid_D", bus.D, 8'h00);
        checkOutput("rst_mid_nCE", bus.nCE, 1'b1);
        checkOutput("rst_mid_nWE", bus.nWE, 1'b1);
        checkOutput("rst_mid_busy", busy, 1'b0);
        checkOutput("rst_mid_err", err_timeout, 1'b0);
        nRST = 1'b1;
        model_last1 = 1'b1;
        stuck = 1'b0;
        repeat (12) @(negedge CLK);
        checkOutput("rst_mid_byte_count", obs_bytes.size() - bb, 1);
        if (obs_bytes.size() > bb)
            checkOutput("rst_mid_latch_byte", obs_bytes[bb], 8'hC3);
        checkOutput("rst_mid_idle", busy, 1'b0);
        checkOutput("rst_mid_no_timeout", err_cyc.size() - eb, 0);

        // Both requesters always busy: strict alternation starting at req0.
        for (int i = 0; i < 4; i++) begin
            addCmd(0, 2'(i), 1'b1, 10'(i + 1));
            addCmd(1, 2'(3 - i), 1'b1, 10'(15 - i));
        end
        runAndCheck("alternate", 0, 1);

        // Randomised mixes of commands and READY profiles.
        for (int r = 0; r < 6; r++) begin
            cnt0 = $urandom_range(0, 3);
            cnt1 = $urandom_range(1, 3);
            for (int i = 0; i < cnt0; i++)
                addCmd(0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 10'($urandom));
            for (int i = 0; i < cnt1; i++)
                addCmd(1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 10'($urandom));
            runAndCheck("random", $urandom_range(0, 2), $urandom_range(1, 2));
        end

        checkOutput("nce_low_during_strobe", nce_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
